// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit: RISC-V load funct3
// encodings, AXI response codes and access-size decoding.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } access_size_t;

    function automatic access_size_t access_size(input logic [2:0] funct3);
        return access_size_t'(funct3[1:0]);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the EX request, WB result and AXI4-Lite data-bus signals of the LSU.
// The master modport is the LSU's view; slave is the surrounding core/bus view.
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ex_valid;
    logic              lsu_ready;
    logic              req_wen;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_rdata;
    logic              wb_err;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  ex_valid, req_wen, req_funct3, req_addr, req_wdata, wb_ready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        output lsu_ready, wb_valid, wb_rdata, wb_err,
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
    );

    modport slave (
        output ex_valid, req_wen, req_funct3, req_addr, req_wdata, wb_ready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        input  lsu_ready, wb_valid, wb_rdata, wb_err,
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store data/strobe placement, load lane select
// and extension, and misalignment/illegal-funct3 detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [31:0] store_wdata,
    output logic [3:0]  store_wstrb,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [4:0]  lane_shift;
    logic [31:0] load_shifted;

    assign lane_shift   = {offset, 3'b000};
    assign store_wdata  = store_data << lane_shift;
    assign load_shifted = load_raw >> lane_shift;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        store_wstrb = 4'b0000;
        misaligned  = 1'b0;
        unique case (access_size(funct3))
            SZ_BYTE: store_wstrb = 4'b0001 << offset;
            SZ_HALF: begin
                store_wstrb = 4'b0011 << offset;
                misaligned  = offset[0];
            end
            SZ_WORD: begin
                store_wstrb = 4'b1111;
                misaligned  = |offset;
            end
            default: misaligned = 1'b1;
        endcase
        // 110 decodes as word size but is not a valid RV32 load/store.
        if (funct3 == 3'b110) misaligned = 1'b1;
    end

    always_comb begin
        load_data = load_shifted;
        case (funct3)
            F3_LB:   load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            F3_LH:   load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            F3_LBU:  load_data = {24'b0, load_shifted[7:0]};
            F3_LHU:  load_data = {16'b0, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one EX request at a time is turned into an AXI4-Lite read
// or write, and a single extended result is handed to WB.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              aw_done_q, w_done_q;

    logic [2:0]        al_funct3;
    logic [1:0]        al_offset;
    logic [DATA_W-1:0] st_wdata, ld_data;
    logic [3:0]        st_wstrb;
    logic              misaligned;
    logic              accept, aw_pend, w_pend, aw_hs, w_hs;

    // The aligner sees the live request while idle and the latched one afterwards.
    assign al_funct3 = (state_q == S_IDLE) ? bus.req_funct3 : funct3_q;
    assign al_offset = (state_q == S_IDLE) ? bus.req_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .funct3      (al_funct3),
        .offset      (al_offset),
        .store_data  (bus.req_wdata),
        .load_raw    (bus.rdata),
        .store_wdata (st_wdata),
        .store_wstrb (st_wstrb),
        .load_data   (ld_data),
        .misaligned  (misaligned)
    );

    assign accept  = (state_q == S_IDLE) && bus.ex_valid;
    assign aw_pend = (state_q == S_AW_W) && !aw_done_q;
    assign w_pend  = (state_q == S_AW_W) && !w_done_q;
    assign aw_hs   = aw_pend && bus.awready;
    assign w_hs    = w_pend && bus.wready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.ex_valid) state_d = misaligned  ? S_DONE :
                                                bus.req_wen ? S_AW_W : S_AR;
            S_AR:   if (bus.arready) state_d = S_R;
            S_R:    if (bus.rvalid) state_d = S_DONE;
            S_AW_W: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_B;
            S_B:    if (bus.bvalid) state_d = S_DONE;
            S_DONE: if (bus.wb_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            funct3_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= bus.req_addr;
                funct3_q  <= bus.req_funct3;
                wdata_q   <= st_wdata;
                wstrb_q   <= st_wstrb;
                rdata_q   <= '0;
                err_q     <= misaligned;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (state_q == S_R && bus.rvalid) begin
                rdata_q <= ld_data;
                err_q   <= (bus.rresp != AXI_RESP_OKAY);
            end
            if (state_q == S_B && bus.bvalid) begin
                rdata_q <= '0;
                err_q   <= (bus.bresp != AXI_RESP_OKAY);
            end
        end
    end

    assign bus.lsu_ready = (state_q == S_IDLE);
    assign bus.arvalid   = (state_q == S_AR);
    assign bus.araddr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.rready    = (state_q == S_R);
    assign bus.awvalid   = aw_pend;
    assign bus.awaddr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.wvalid    = w_pend;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.bready    = (state_q == S_B);
    assign bus.wb_valid  = (state_q == S_DONE);
    assign bus.wb_rdata  = rdata_q;
    assign bus.wb_err    = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a small AXI4-Lite slave with programmable waits,
// directed scenarios and a randomized run against a byte-level reference model.
module tb_lsu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Slave configuration, written only by the test sequence.
    int         ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [1:0] r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;
    logic [31:0] mem [16];

    // Slave observations, written only by the slave process.
    int          ar_count = 0, aw_count = 0, w_count = 0, b_count = 0;
    int          aw_viol = 0, w_viol = 0, aw_drop = 0, b_early = 0;
    logic [31:0] last_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;

    initial begin : slave
        int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        logic aw_got, w_got;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 1'b0; w_got = 1'b0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        forever begin
            @(negedge clk);
            bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
            if (!rst_n) begin
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                aw_got = 1'b0; w_got = 1'b0;
            end else begin
                if (bus.arvalid) begin
                    if (ar_cnt >= ar_wait) begin
                        bus.arready = 1; ar_cnt = 0; ar_count++; last_araddr = bus.araddr;
                    end else ar_cnt++;
                end else ar_cnt = 0;
                if (bus.rready) begin
                    if (r_cnt >= r_wait) begin
                        bus.rvalid = 1; bus.rdata = mem[last_araddr[5:2]]; bus.rresp = r_resp_cfg; r_cnt = 0;
                    end else r_cnt++;
                end else r_cnt = 0;
                if (bus.awvalid) begin
                    if (aw_got) aw_viol++;
                    else if (aw_cnt >= aw_wait) begin
                        bus.awready = 1; aw_got = 1'b1; aw_cnt = 0; aw_count++; cap_awaddr = bus.awaddr;
                    end else aw_cnt++;
                end else begin
                    aw_cnt = 0;
                    if (w_got && !aw_got) aw_drop++;
                end
                if (bus.wvalid) begin
                    if (w_got) w_viol++;
                    else if (w_cnt >= w_wait) begin
                        bus.wready = 1; w_got = 1'b1; w_cnt = 0; w_count++;
                        cap_wdata = bus.wdata; cap_wstrb = bus.wstrb;
                    end else w_cnt++;
                end else w_cnt = 0;
                if (bus.bready) begin
                    if (!(aw_got && w_got)) b_early++;
                    else if (b_cnt >= b_wait) begin
                        bus.bvalid = 1; bus.bresp = b_resp_cfg; b_count++; b_cnt = 0;
                        aw_got = 1'b0; w_got = 1'b0;
                    end else b_cnt++;
                end else b_cnt = 0;
            end
        end
    end

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input int off);
        logic [31:0] v;
        v = word >> (8 * off);
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 32'd256;   end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 32'd65536; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int size;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        size = 1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                              input int off, input logic [31:0] data);
        logic [31:0] res;
        int size;
        res  = old;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) res[8*(off+i) +: 8] = data[8*i +: 8];
        return res;
    endfunction

    function automatic logic [31:0] apply_strobe(input logic [31:0] old, input logic [31:0] wd,
                                                 input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        return res;
    endfunction

    // ---------------- request drivers ----------------
    task automatic run_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat);
        bus.ex_valid = 1; bus.req_wen = wen; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        @(negedge clk);
        bus.ex_valid = 0;
        lat = 1;
        while (!bus.wb_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (bus.wb_valid !== 1'b1) begin
            bad++;
            $display("FAIL wb_valid_timeout: addr=%h f3=%0d saw wb_valid=%b, need 1", addr, f3, bus.wb_valid);
        end
        rd = bus.wb_rdata;
        er = bus.wb_err;
    endtask

    task automatic finish_req;
        bus.wb_ready = 1;
        @(negedge clk);
        bus.wb_ready = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        #12;
        total++;
        if ({bus.lsu_ready, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
             bus.wb_valid, bus.wb_err} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, need 10000000",
                     {bus.lsu_ready, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                      bus.bready, bus.wb_valid, bus.wb_err});
        end
        total++;
        if (bus.wb_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h, need 0", bus.wb_rdata);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_lw;
        logic [31:0] rd; logic er; int lat;
        mem[1] = 32'hDEAD_BEEF;
        run_req(0, 3'b010, 32'h8000_0004, 0, rd, er, lat);
        total++;
        if (lat !== 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            bad++;
            $display("FAIL lw_basic: lat=%0d rd=%h err=%b, need lat=3 rd=deadbeef err=0", lat, rd, er);
        end
        total++;
        if (last_araddr !== 32'h8000_0004) begin
            bad++;
            $display("FAIL lw_araddr: got %h, need 80000004", last_araddr);
        end
        finish_req();
    endtask

    task automatic test_lb_lbu;
        logic [31:0] rd; logic er; int lat;
        mem[0] = 32'h80FF_0000;
        run_req(0, 3'b000, 32'h8000_0003, 0, rd, er, lat);
        total++;
        if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin
            bad++;
            $display("FAIL lb_sext: rd=%h err=%b, need ffffff80 err=0", rd, er);
        end
        finish_req();
        run_req(0, 3'b100, 32'h8000_0003, 0, rd, er, lat);
        total++;
        if (rd !== 32'h0000_0080 || er !== 1'b0) begin
            bad++;
            $display("FAIL lbu_zext: rd=%h err=%b, need 00000080 err=0", rd, er);
        end
        finish_req();
    endtask

    task automatic test_sh;
        logic [31:0] rd; logic er; int lat;
        run_req(1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, rd, er, lat);
        total++;
        if (cap_wstrb !== 4'b1100 || cap_wdata !== 32'hABCD_0000) begin
            bad++;
            $display("FAIL sh_lanes: wstrb=%b wdata=%h, need 1100 abcd0000", cap_wstrb, cap_wdata);
        end
        total++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
            bad++;
            $display("FAIL sh_result: rd=%h err=%b lat=%0d, need 0 0 3", rd, er, lat);
        end
        finish_req();
        mem[0] = apply_strobe(mem[0], cap_wdata, cap_wstrb);
    endtask

    task automatic test_sw_delayed;
        logic [31:0] rd, wd; logic er; int lat, b0, v0;
        wd = $urandom;
        aw_wait = 3; w_wait = 1;
        b0 = b_count;
        v0 = aw_viol + w_viol + aw_drop + b_early;
        run_req(1, 3'b010, 32'h8000_0008, wd, rd, er, lat);
        total++;
        if (b_count - b0 !== 1 || aw_viol + w_viol + aw_drop + b_early - v0 !== 0) begin
            bad++;
            $display("FAIL sw_delayed_proto: b=%0d aw_viol=%0d w_viol=%0d aw_drop=%0d b_early=%0d, need b=1 rest 0",
                     b_count - b0, aw_viol, w_viol, aw_drop, b_early);
        end
        total++;
        if (cap_wdata !== wd || cap_wstrb !== 4'b1111 || cap_awaddr !== 32'h8000_0008 || er !== 1'b0) begin
            bad++;
            $display("FAIL sw_delayed_data: wdata=%h wstrb=%b awaddr=%h err=%b, need %h 1111 80000008 0",
                     cap_wdata, cap_wstrb, cap_awaddr, er, wd);
        end
        finish_req();
        mem[2] = wd;
        aw_wait = 0; w_wait = 0;
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic er; int lat, ar0, aw0;
        ar0 = ar_count; aw0 = aw_count;
        run_req(0, 3'b010, 32'h8000_0002, 0, rd, er, lat);
        total++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || ar_count !== ar0) begin
            bad++;
            $display("FAIL lw_misaligned: lat=%0d err=%b rd=%h ar=%0d, need 1 1 0 0", lat, er, rd, ar_count - ar0);
        end
        finish_req();
        run_req(1, 3'b001, 32'h8000_0005, 32'hFFFF_FFFF, rd, er, lat);
        total++;
        if (lat !== 1 || er !== 1'b1 || aw_count !== aw0) begin
            bad++;
            $display("FAIL sh_misaligned: lat=%0d err=%b aw=%0d, need 1 1 0", lat, er, aw_count - aw0);
        end
        finish_req();
        run_req(0, 3'b011, 32'h8000_0000, 0, rd, er, lat);
        total++;
        if (lat !== 1 || er !== 1'b1 || ar_count !== ar0) begin
            bad++;
            $display("FAIL funct3_illegal: lat=%0d err=%b ar=%0d, need 1 1 0", lat, er, ar_count - ar0);
        end
        finish_req();
    endtask

    task automatic test_bus_err;
        logic [31:0] rd; logic er; int lat;
        r_resp_cfg = 2'b10;
        run_req(0, 3'b010, 32'h8000_0004, 0, rd, er, lat);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL rresp_err: err=%b, need 1", er);
        end
        finish_req();
        r_resp_cfg = 2'b00;
        b_resp_cfg = 2'b11;
        run_req(1, 3'b000, 32'h8000_0030, 32'h0000_00AA, rd, er, lat);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL bresp_err: err=%b rd=%h, need 1 0", er, rd);
        end
        finish_req();
        mem[12] = apply_strobe(mem[12], cap_wdata, cap_wstrb);
        b_resp_cfg = 2'b00;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, rd0; logic er, er0; int lat;
        mem[3] = 32'h0000_8001;
        run_req(0, 3'b001, 32'h8000_000C, 0, rd0, er0, lat);
        total++;
        if (rd0 !== 32'h0000_8001 - 32'd65536 + 32'd65536 - 32'h0000_8001 + 32'hFFFF_8001 || er0 !== 1'b0) begin
            bad++;
            $display("FAIL lh_sext: rd=%h err=%b, need ffff8001 0", rd0, er0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({bus.wb_valid, bus.lsu_ready, bus.wb_err} !== {1'b1, 1'b0, er0} || bus.wb_rdata !== rd0) begin
                bad++;
                $display("FAIL hold_stable[%0d]: valid=%b ready=%b err=%b rd=%h, need 1 0 %b %h",
                         i, bus.wb_valid, bus.lsu_ready, bus.wb_err, bus.wb_rdata, er0, rd0);
            end
        end
        finish_req();
        run_req(1, 3'b010, 32'h8000_0014, 32'h5A5A_5A5A, rd, er, lat);
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL back_to_back_lat: lat=%0d, need 3", lat);
        end
        finish_req();
        mem[5] = 32'h5A5A_5A5A;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat, n;
        ar_wait = 20;
        bus.ex_valid = 1; bus.req_wen = 0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h8000_0010;
        @(negedge clk);
        bus.ex_valid = 0;
        n = 0;
        while (!bus.arvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.arvalid !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ar: arvalid=%b, need 1", bus.arvalid);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (bus.arvalid !== 1'b0 || bus.lsu_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_async: arvalid=%b lsu_ready=%b, need 0 1", bus.arvalid, bus.lsu_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        ar_wait = 0;
        @(negedge clk);
        total++;
        if ({bus.lsu_ready, bus.arvalid, bus.wb_valid} !== 3'b100) begin
            bad++;
            $display("FAIL mid_reset_idle: ready/arvalid/wb_valid=%b, need 100",
                     {bus.lsu_ready, bus.arvalid, bus.wb_valid});
        end
        run_req(0, 3'b010, 32'h8000_0010, 0, rd, er, lat);
        total++;
        if (rd !== mem[4] || er !== 1'b0 || lat !== 3) begin
            bad++;
            $display("FAIL mid_reset_recover: rd=%h err=%b lat=%0d, need %h 0 3", rd, er, lat, mem[4]);
        end
        finish_req();
    endtask

    task automatic test_random;
        logic [2:0]  ld_ops [5];
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd, old, exp_rd, exp_word, got_word;
        logic        wen, er, mis, exp_err;
        int          lat, ar0, aw0, exp_tr;
        ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 60; i++) begin
            wen  = 1'($urandom_range(0, 1));
            f3   = wen ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(6, 7));
            addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
            wd   = $urandom;
            ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
            aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
            r_resp_cfg = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            b_resp_cfg = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            mis = ref_misaligned(f3, addr);
            old = mem[addr[5:2]];
            ar0 = ar_count; aw0 = aw_count;
            run_req(wen, f3, addr, wd, rd, er, lat);
            finish_req();
            exp_err = mis ? 1'b1 : (wen ? (b_resp_cfg != 2'b00) : (r_resp_cfg != 2'b00));
            exp_rd  = (mis || wen) ? 32'h0 : ref_load(old, f3, int'(addr % 4));
            total++;
            if (rd !== exp_rd || er !== exp_err) begin
                bad++;
                $display("FAIL rand_result[%0d]: wen=%b f3=%0d addr=%h rd=%h err=%b, need %h %b",
                         i, wen, f3, addr, rd, er, exp_rd, exp_err);
            end
            exp_tr = mis ? 0 : 1;
            total++;
            if ((ar_count - ar0) !== (wen ? 0 : exp_tr) || (aw_count - aw0) !== (wen ? exp_tr : 0)) begin
                bad++;
                $display("FAIL rand_traffic[%0d]: ar=%0d aw=%0d, need ar=%0d aw=%0d", i,
                         ar_count - ar0, aw_count - aw0, wen ? 0 : exp_tr, wen ? exp_tr : 0);
            end
            if (!mis && !wen) begin
                total++;
                if (last_araddr !== (addr & 32'hFFFF_FFFC)) begin
                    bad++;
                    $display("FAIL rand_araddr[%0d]: got %h, need %h", i, last_araddr, addr & 32'hFFFF_FFFC);
                end
            end
            if (!mis && wen) begin
                exp_word = ref_store(old, f3, int'(addr % 4), wd);
                got_word = apply_strobe(old, cap_wdata, cap_wstrb);
                total++;
                if (got_word !== exp_word || cap_awaddr !== (addr & 32'hFFFF_FFFC)) begin
                    bad++;
                    $display("FAIL rand_store[%0d]: f3=%0d addr=%h word=%h awaddr=%h, need %h %h",
                             i, f3, addr, got_word, cap_awaddr, exp_word, addr & 32'hFFFF_FFFC);
                end
                mem[addr[5:2]] = exp_word;
            end
        end
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_n = 0;
        bus.ex_valid = 0; bus.req_wen = 0; bus.req_funct3 = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.wb_ready = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_sw_delayed();
        test_misaligned();
        test_bus_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
